// File: rtl/idma_reg64_driver.sv
// idma_reg64_driver: register-bus initiator that programs an idma_reg64_frontend.
// It accepts one job, writes src/dst/num_bytes/conf, launches the job by reading
// next_id, polls done until that ID has retired, then returns a response.
// Optional feature: define IDMA_REG_DRIVER_TIMEOUT_EN to build the poll timeout.

package idma_reg64_driver_pkg;

   typedef struct packed {
      logic [63:0] addr;
      logic        write;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

endpackage

module idma_reg64_driver #(
   parameter int unsigned          AddrWidth     = 64,
   parameter logic [AddrWidth-1:0] BaseAddr      = '0,
   parameter int unsigned          PollGap       = 4,
   parameter int unsigned          TimeoutCycles = 1024,
   parameter type                  reg_req_t     = idma_reg64_driver_pkg::reg_req_t,
   parameter type                  reg_rsp_t     = idma_reg64_driver_pkg::reg_rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [AddrWidth-1:0] job_src_i,
   input  logic [AddrWidth-1:0] job_dst_i,
   input  logic [AddrWidth-1:0] job_len_i,
   input  logic [2:0]           job_conf_i,
   input  logic                 job_valid_i,
   output logic                 job_ready_o,
   output logic [63:0]          rsp_id_o,
   output logic                 rsp_error_o,
   output logic                 rsp_timeout_o,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output reg_req_t             reg_req_o,
   input  reg_rsp_t             reg_rsp_i
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] WR_SRC    = 4'd1;
   localparam logic [3:0] WR_DST    = 4'd2;
   localparam logic [3:0] WR_LEN    = 4'd3;
   localparam logic [3:0] WR_CONF   = 4'd4;
   localparam logic [3:0] RD_ID     = 4'd5;
   localparam logic [3:0] POLL_RD   = 4'd6;
   localparam logic [3:0] POLL_WAIT = 4'd7;
   localparam logic [3:0] RSP       = 4'd8;

   localparam logic [7:0] GapLoad = (PollGap > 0) ? 8'(PollGap - 1) : 8'd0;

   logic [3:0]           state_q, state_d;
   reg_req_t             req_q, req_d;
   logic [AddrWidth-1:0] src_q, dst_q, len_q;
   logic [2:0]           conf_q;
   logic [63:0]          id_q, id_d;
   logic [7:0]           gap_q, gap_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_error_q;
   logic [63:0]          rsp_id_q;
   logic                 job_accept, access_done;
   logic [63:0]          done_val, done_diff;
   logic                 done_ok, timeout_hit;
   logic                 go_rsp, rsp_bus_err, rsp_to;

   function automatic logic [AddrWidth-1:0] reg_addr(input logic [7:0] off);
      return BaseAddr + AddrWidth'(off);
   endfunction

   // Build the request issued in state st; only the four config writes carry data.
   function automatic reg_req_t build_req(input logic [3:0] st, input logic [63:0] wdata);
      reg_req_t r;
      r       = '0;
      r.valid = 1'b1;
      case (st)
         WR_SRC:  r.addr = reg_addr(8'h00);
         WR_DST:  r.addr = reg_addr(8'h08);
         WR_LEN:  r.addr = reg_addr(8'h10);
         WR_CONF: r.addr = reg_addr(8'h18);
         RD_ID:   r.addr = reg_addr(8'h28);
         default: r.addr = reg_addr(8'h30);
      endcase
      if (st inside {WR_SRC, WR_DST, WR_LEN, WR_CONF}) begin
         r.write = 1'b1;
         r.wdata = wdata;
         r.wstrb = 8'hFF;
      end
      return r;
   endfunction

   assign job_ready_o = (state_q == IDLE) && !rst_i;
   assign job_accept  = job_ready_o && job_valid_i;
   assign access_done = req_q.valid && reg_rsp_i.ready;

   // Wrap-safe completion test: done - id has its sign bit clear when done is at
   // or past id modulo 2^64.
   assign done_val  = reg_rsp_i.rdata;
   assign done_diff = done_val - id_q;
   assign done_ok   = !done_diff[63];

`ifdef IDMA_REG_DRIVER_TIMEOUT_EN
   logic [31:0] to_cnt_q;
   logic        rsp_timeout_q;

   assign timeout_hit   = (to_cnt_q >= 32'(TimeoutCycles));
   assign rsp_timeout_o = rsp_timeout_q;

   // Poll-time counter: restarts when the job is launched, saturates at the limit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt_q <= '0;
      end else if (state_q == RD_ID && access_done) begin
         to_cnt_q <= '0;
      end else if ((state_q == POLL_RD || state_q == POLL_WAIT) && !timeout_hit) begin
         to_cnt_q <= to_cnt_q + 32'd1;
      end
   end

   // Timeout cause flag, captured together with the rest of the response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_timeout_q <= 1'b0;
      end else if (go_rsp) begin
         rsp_timeout_q <= rsp_to;
      end
   end
`else
   assign timeout_hit   = 1'b0;
   assign rsp_timeout_o = 1'b0;
`endif

   // Next-state and next-request decode for the job sequencer.
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      req_d       = req_q;
      id_d        = id_q;
      gap_d       = gap_q;
      rsp_valid_d = rsp_valid_q;
      go_rsp      = 1'b0;
      rsp_bus_err = 1'b0;
      rsp_to      = 1'b0;

      case (state_q)
         IDLE: begin
            if (job_accept) begin
               state_d = WR_SRC;
               req_d   = build_req(WR_SRC, 64'(job_src_i));
               id_d    = '0;
            end
         end
         WR_SRC, WR_DST, WR_LEN, WR_CONF, RD_ID: begin
            if (access_done) begin
               if (reg_rsp_i.error) begin
                  go_rsp      = 1'b1;
                  rsp_bus_err = 1'b1;
               end else begin
                  case (state_q)
                     WR_SRC: begin
                        state_d = WR_DST;
                        req_d   = build_req(WR_DST, 64'(dst_q));
                     end
                     WR_DST: begin
                        state_d = WR_LEN;
                        req_d   = build_req(WR_LEN, 64'(len_q));
                     end
                     WR_LEN: begin
                        state_d = WR_CONF;
                        req_d   = build_req(WR_CONF, {61'b0, conf_q});
                     end
                     WR_CONF: begin
                        state_d = RD_ID;
                        req_d   = build_req(RD_ID, 64'h0);
                     end
                     default: begin
                        id_d    = reg_rsp_i.rdata;
                        state_d = POLL_RD;
                        req_d   = build_req(POLL_RD, 64'h0);
                     end
                  endcase
               end
            end
         end
         POLL_RD: begin
            if (access_done) begin
               if (reg_rsp_i.error) begin
                  go_rsp      = 1'b1;
                  rsp_bus_err = 1'b1;
               end else if (done_ok) begin
                  go_rsp = 1'b1;
               end else if (timeout_hit) begin
                  go_rsp = 1'b1;
                  rsp_to = 1'b1;
               end else if (PollGap != 0) begin
                  state_d = POLL_WAIT;
                  req_d   = '0;
                  gap_d   = GapLoad;
               end
               // With no gap the same done read is simply reissued back-to-back.
            end
         end
         POLL_WAIT: begin
            if (timeout_hit) begin
               go_rsp = 1'b1;
               rsp_to = 1'b1;
            end else if (gap_q == 8'd0) begin
               state_d = POLL_RD;
               req_d   = build_req(POLL_RD, 64'h0);
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = '0;
         end
      endcase

      if (go_rsp) begin
         state_d     = RSP;
         req_d       = '0;
         rsp_valid_d = 1'b1;
      end
   end

   // Control state, the registered bus request and the registered response.
   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values of the others.
      if (rst_i) begin
         state_q     <= IDLE;
         req_q       <= '0;
         id_q        <= '0;
         gap_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         id_q        <= id_d;
         gap_q       <= gap_d;
         rsp_valid_q <= rsp_valid_d;
         if (go_rsp) begin
            rsp_id_q    <= id_q;
            rsp_error_q <= rsp_bus_err | rsp_to;
         end
      end
   end

   // Job payload capture at acceptance.
   always_ff @(posedge clk_i) begin
      // NOTE: payload registers carry no reset; they are always loaded on
      // acceptance before anything reads them.
      if (job_accept) begin
         src_q  <= job_src_i;
         dst_q  <= job_dst_i;
         len_q  <= job_len_i;
         conf_q <= job_conf_i;
      end
   end

   assign reg_req_o   = req_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_error_o = rsp_error_q;

endmodule
